// File: rtl/inverter_block_if.sv
// rtl/inverter_block_if.sv - operand/result bundle for the registered add/sub cell
interface inverter_block_if #(
  parameter int WIDTH = 1
);
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             z;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output cin, a, b, sub, in_valid,
    input  y, z, ovf, zero, out_valid
  );

  modport slave (
    input  cin, a, b, sub, in_valid,
    output y, z, ovf, zero, out_valid
  );
endinterface

// File: rtl/inverter_block.sv
// rtl/inverter_block.sv - registered ripple-carry adder/subtractor with operand-B inverter
// Results and flags land one clock after a sampling edge; they hold while in_valid is low.
module inverter_block #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  inverter_block_if.slave bus
);
  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  logic [WIDTH-1:0] y_q;
  logic             z_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid_q;

  // sub only inverts; the +1 of two's-complement subtraction comes from cin
  assign bp   = bus.sub ? ~bus.b : bus.b;
  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.a[i] ^ bp[i] ^ c[i];
    assign c[i+1] = (bus.a[i] & bp[i]) | (c[i] & (bus.a[i] ^ bp[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      z_q         <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q    <= s;
        z_q    <= c[WIDTH];
        ovf_q  <= c[WIDTH-1] ^ c[WIDTH];
        zero_q <= (s == '0);
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.z         = z_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_inverter_block.sv
// tb/tb_inverter_block.sv - directed and randomized checks of inverter_block at widths 1, 8 and 16
module tb_inverter_block;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  inverter_block_if #(.WIDTH(1))  if1 ();
  inverter_block_if #(.WIDTH(8))  if8 ();
  inverter_block_if #(.WIDTH(16)) if16 ();

  inverter_block #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  inverter_block #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  inverter_block #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_y1"},  64'(if1.y), 64'd0);
    chk({tag, "_ov1"}, 64'(if1.out_valid), 64'd0);
    chk({tag, "_y8"},  64'(if8.y), 64'd0);
    chk({tag, "_z8"},  64'(if8.z), 64'd0);
    chk({tag, "_o8"},  64'(if8.ovf), 64'd0);
    chk({tag, "_zr8"}, 64'(if8.zero), 64'd0);
    chk({tag, "_ov8"}, 64'(if8.out_valid), 64'd0);
    chk({tag, "_y16"}, 64'(if16.y), 64'd0);
    chk({tag, "_ov16"}, 64'(if16.out_valid), 64'd0);
  endtask

  task automatic vec1(input logic cin, input logic a, input logic b,
                      input logic ey, input logic ez, input logic eo, input logic ezr);
    @(negedge clk);
    if1.cin = cin; if1.a = a; if1.b = b; if1.sub = 1'b0; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("w1_y",   64'(if1.y), 64'(ey));
    chk("w1_z",   64'(if1.z), 64'(ez));
    chk("w1_ovf", 64'(if1.ovf), 64'(eo));
    chk("w1_zero", 64'(if1.zero), 64'(ezr));
    chk("w1_vld", 64'(if1.out_valid), 64'd1);
  endtask

  task automatic vec8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                      input logic [7:0] ey, input logic ez, input logic eo, input logic ezr);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.sub = sub; if8.cin = cin; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("w8_y",   64'(if8.y), 64'(ey));
    chk("w8_z",   64'(if8.z), 64'(ez));
    chk("w8_ovf", 64'(if8.ovf), 64'(eo));
    chk("w8_zero", 64'(if8.zero), 64'(ezr));
    chk("w8_vld", 64'(if8.out_valid), 64'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, bp;
    logic        rc, rs, rv;
    logic [16:0] full;
    logic [15:0] ey;
    logic        ez, eo, ezr, ev;

    if1.cin = 0;  if1.a = '0;  if1.b = '0;  if1.sub = 0;  if1.in_valid = 0;
    if8.cin = 0;  if8.a = '0;  if8.b = '0;  if8.sub = 0;  if8.in_valid = 0;
    if16.cin = 0; if16.a = '0; if16.b = '0; if16.sub = 0; if16.in_valid = 0;

    #3;
    chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // width-1 full adder vectors
    vec1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vec1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vec1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vec1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    if1.in_valid = 1'b0;

    // width-8 subtraction and wrap-around
    vec8(8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    vec8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    vec8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    vec8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

    // hold with junk operands while in_valid is low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if8.in_valid = 1'b0;
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.cin = 1'($urandom); if8.sub = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_y",   64'(if8.y), 64'h80);
      chk("hold_z",   64'(if8.z), 64'd0);
      chk("hold_ovf", 64'(if8.ovf), 64'd1);
      chk("hold_vld", 64'(if8.out_valid), 64'd0);
    end

    // asynchronous reset while y is nonzero, mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized width-16 stream with a reset pulse in the middle
    ey = '0; ez = 0; eo = 0; ezr = 0; ev = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rst_n = 1'b1;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom); rv = 1'($urandom);
      if (n % 37 == 5) begin ra = 16'hFFFF; rb = 16'h0000; rs = 1'b0; rc = 1'b1; end
      if16.a = ra; if16.b = rb; if16.cin = rc; if16.sub = rs; if16.in_valid = rv;
      bp = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bp} + {16'd0, rc};
      ev = rv;
      if (rv) begin
        ey  = full[15:0];
        ez  = full[16];
        eo  = (ra[15] == bp[15]) && (full[15] != ra[15]);
        ezr = (full[15:0] == 16'd0);
      end
      @(posedge clk); #1;
      chk("r16_y",   64'(if16.y), 64'(ey));
      chk("r16_z",   64'(if16.z), 64'(ez));
      chk("r16_ovf", 64'(if16.ovf), 64'(eo));
      chk("r16_zero", 64'(if16.zero), 64'(ezr));
      chk("r16_vld", 64'(if16.out_valid), 64'(ev));
      if (n == 100) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("r16_rst_y",   64'(if16.y), 64'd0);
        chk("r16_rst_z",   64'(if16.z), 64'd0);
        chk("r16_rst_ovf", 64'(if16.ovf), 64'd0);
        chk("r16_rst_zero", 64'(if16.zero), 64'd0);
        chk("r16_rst_vld", 64'(if16.out_valid), 64'd0);
        ey = '0; ez = 0; eo = 0; ezr = 0; ev = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
